power_sequencer: RTL and testbench

POWER_SEQUENCER -- requirements
Module: power_sequencer

---
 rtl/power_sequencer.sv | 131 +++++++++++++
 tb/tb_power_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/power_sequencer.sv
// Orders three regulator rails up (io, core, ddr) and down (ddr, core, io), with power-good supervision and a latched fault.
// Latency: inputs pass a 2-flop synchronizer, and outputs update on the edge that changes state; no backpressure.
module power_sequencer #(
    parameter int STEP_DLY   = 16,
    parameter int SETTLE_DLY = 64,
    parameter int PG_TIMEOUT = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pwr_req,
    input  logic       pg_vdd_io,
    input  logic       pg_vdd_core,
    input  logic       pg_vdd_ddr,
    output logic       en_vdd_io,
    output logic       en_vdd_core,
    output logic       en_vdd_ddr,
    output logic       power_ok,
    output logic       seq_fault,
    output logic [3:0] seq_state
);

    if (!(STEP_DLY >= 1 && SETTLE_DLY >= 1 && STEP_DLY < PG_TIMEOUT && PG_TIMEOUT <= 65535)) begin : g_param_check
        $error("power_sequencer: requires 1 <= STEP_DLY < PG_TIMEOUT <= 65535 and SETTLE_DLY >= 1");
    end

    typedef enum logic [3:0] {
        S_OFF     = 4'd0,
        S_EN_IO   = 4'd1,
        S_EN_CORE = 4'd2,
        S_EN_DDR  = 4'd3,
        S_SETTLE  = 4'd4,
        S_ON      = 4'd5,
        S_DN_DDR  = 4'd6,
        S_DN_CORE = 4'd7,
        S_DN_IO   = 4'd8,
        S_FAULT   = 4'd9
    } state_t;

    localparam logic [15:0] STEP_M1   = 16'(STEP_DLY - 1);
    localparam logic [15:0] SETTLE_M1 = 16'(SETTLE_DLY - 1);
    localparam logic [15:0] TO_M1     = 16'(PG_TIMEOUT - 1);

    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic        pwr_req_s;
    logic        pg_io_s;
    logic        pg_core_s;
    logic        pg_ddr_s;
    logic        all_pg_s;
    state_t      state;
    state_t      next_state;
    logic [15:0] dwell_cnt;

    assign {pwr_req_s, pg_io_s, pg_core_s, pg_ddr_s} = sync2;
    assign all_pg_s = pg_io_s & pg_core_s & pg_ddr_s;

    function automatic logic [2:0] rail_enables(input state_t s);
        case (s)
            S_EN_IO, S_DN_CORE:          rail_enables = 3'b100;
            S_EN_CORE, S_DN_DDR:         rail_enables = 3'b110;
            S_EN_DDR, S_SETTLE, S_ON:    rail_enables = 3'b111;
            default:                     rail_enables = 3'b000;
        endcase
    endfunction

    // Fault checks outrank a dropped request, which outranks advancing.
    always_comb begin
        next_state = state;
        case (state)
            S_OFF:     if (pwr_req_s) next_state = S_EN_IO;
            S_EN_IO: begin
                if (!pg_io_s && dwell_cnt == TO_M1)        next_state = S_FAULT;
                else if (!pwr_req_s)                       next_state = S_DN_DDR;
                else if (pg_io_s && dwell_cnt >= STEP_M1)  next_state = S_EN_CORE;
            end
            S_EN_CORE: begin
                if (!pg_core_s && dwell_cnt == TO_M1)       next_state = S_FAULT;
                else if (!pwr_req_s)                        next_state = S_DN_DDR;
                else if (pg_core_s && dwell_cnt >= STEP_M1) next_state = S_EN_DDR;
            end
            S_EN_DDR: begin
                if (!pg_ddr_s && dwell_cnt == TO_M1)        next_state = S_FAULT;
                else if (!pwr_req_s)                        next_state = S_DN_DDR;
                else if (pg_ddr_s && dwell_cnt >= STEP_M1)  next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (!all_pg_s)                   next_state = S_FAULT;
                else if (!pwr_req_s)             next_state = S_DN_DDR;
                else if (dwell_cnt == SETTLE_M1) next_state = S_ON;
            end
            S_ON: begin
                if (!all_pg_s)       next_state = S_FAULT;
                else if (!pwr_req_s) next_state = S_DN_DDR;
            end
            S_DN_DDR:  if (dwell_cnt == STEP_M1) next_state = S_DN_CORE;
            S_DN_CORE: if (dwell_cnt == STEP_M1) next_state = S_DN_IO;
            S_DN_IO:   if (dwell_cnt == STEP_M1) next_state = S_OFF;
            S_FAULT:   if (!pwr_req_s && dwell_cnt == STEP_M1) next_state = S_OFF;
            default:   next_state = S_OFF;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            state       <= S_OFF;
            dwell_cnt   <= '0;
            en_vdd_io   <= 1'b0;
            en_vdd_core <= 1'b0;
            en_vdd_ddr  <= 1'b0;
            power_ok    <= 1'b0;
            seq_fault   <= 1'b0;
            seq_state   <= 4'd0;
        end else begin
            sync1 <= {pwr_req, pg_vdd_io, pg_vdd_core, pg_vdd_ddr};
            sync2 <= sync1;
            state <= next_state;
            // In FAULT the dwell only accumulates while the request stays low.
            if (next_state != state || (state == S_FAULT && pwr_req_s))
                dwell_cnt <= '0;
            else if (dwell_cnt != 16'hFFFF)
                dwell_cnt <= dwell_cnt + 16'd1;
            {en_vdd_io, en_vdd_core, en_vdd_ddr} <= rail_enables(next_state);
            power_ok  <= (next_state == S_ON);
            seq_fault <= (next_state == S_FAULT);
            seq_state <= next_state;
        end
    end

endmodule

// File: tb/tb_power_sequencer.sv
// Bench for power_sequencer with STEP_DLY=4, SETTLE_DLY=8, PG_TIMEOUT=32.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
module tb_power_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       pwr_req;
    logic       pg_vdd_io;
    logic       pg_vdd_core;
    logic       pg_vdd_ddr;
    logic       en_vdd_io;
    logic       en_vdd_core;
    logic       en_vdd_ddr;
    logic       power_ok;
    logic       seq_fault;
    logic [3:0] seq_state;

    power_sequencer #(.STEP_DLY(4), .SETTLE_DLY(8), .PG_TIMEOUT(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .pwr_req     (pwr_req),
        .pg_vdd_io   (pg_vdd_io),
        .pg_vdd_core (pg_vdd_core),
        .pg_vdd_ddr  (pg_vdd_ddr),
        .en_vdd_io   (en_vdd_io),
        .en_vdd_core (en_vdd_core),
        .en_vdd_ddr  (en_vdd_ddr),
        .power_ok    (power_ok),
        .seq_fault   (seq_fault),
        .seq_state   (seq_state)
    );

    always #5 clock = ~clock;

    // Output vector: {seq_state[3:0], en io/core/ddr, power_ok, seq_fault}
    typedef struct {
        string    name;
        bit       rst;
        bit       req;
        bit [2:0] pg;
        int       edges;
        bit [8:0] exp;
    } vec_t;

    typedef struct {
        string    name;
        bit [8:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   split;

    wire [8:0] act = {seq_state, en_vdd_io, en_vdd_core, en_vdd_ddr, power_ok, seq_fault};

    function automatic bit [8:0] o(input bit [3:0] st, input bit [2:0] en, input bit ok, input bit flt);
        return {st, en, ok, flt};
    endfunction

    function automatic void add(input string n, input bit r, input bit q, input bit [2:0] pg,
                                input int e, input bit [8:0] x);
        vec_t v;
        v.name = n; v.rst = r; v.req = q; v.pg = pg; v.edges = e; v.exp = x;
        tbl.push_back(v);
    endfunction

    task automatic drive(input bit r, input bit q, input bit [2:0] pg);
        reset = r;
        pwr_req = q;
        {pg_vdd_io, pg_vdd_core, pg_vdd_ddr} = pg;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string n, input bit [8:0] x);
        sb_t s;
        s.name = n; s.exp = x;
        sb.push_back(s);
    endtask

    task automatic check_pop();
        sb_t s;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got %b want an entry", act);
        end else begin
            s = sb.pop_front();
            if (act !== s.exp) begin
                n_bad++;
                $display("FAIL %s: got st=%0d en=%b ok=%b flt=%b, want st=%0d en=%b ok=%b flt=%b",
                         s.name, act[8:5], act[4:2], act[1], act[0],
                         s.exp[8:5], s.exp[4:2], s.exp[1], s.exp[0]);
            end
        end
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].pg);
            expect_out(tbl[i].name, tbl[i].exp);
            tick(tbl[i].edges);
            check_pop();
        end
    endtask

    // Rail ordering must hold on every cycle.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            n_cmp++;
            if ((en_vdd_core && !en_vdd_io) || (en_vdd_ddr && !en_vdd_core)) begin
                n_bad++;
                $display("FAIL rail_order: got en=%b%b%b, want no rail on above an off rail",
                         en_vdd_io, en_vdd_core, en_vdd_ddr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal power-up and ordered power-down
        add("reset",        1, 0, 3'b111, 3,  o(0, 3'b000, 0, 0));
        add("idle_off",     0, 0, 3'b111, 5,  o(0, 3'b000, 0, 0));
        add("req_sync",     0, 1, 3'b111, 2,  o(0, 3'b000, 0, 0));
        add("en_io",        0, 1, 3'b111, 1,  o(1, 3'b100, 0, 0));
        add("io_dwell",     0, 1, 3'b111, 3,  o(1, 3'b100, 0, 0));
        add("en_core",      0, 1, 3'b111, 1,  o(2, 3'b110, 0, 0));
        add("en_ddr",       0, 1, 3'b111, 4,  o(3, 3'b111, 0, 0));
        add("settle",       0, 1, 3'b111, 4,  o(4, 3'b111, 0, 0));
        add("settle_end",   0, 1, 3'b111, 7,  o(4, 3'b111, 0, 0));
        add("power_ok",     0, 1, 3'b111, 1,  o(5, 3'b111, 1, 0));
        add("on_hold",      0, 1, 3'b111, 10, o(5, 3'b111, 1, 0));
        add("dn_sync",      0, 0, 3'b111, 2,  o(5, 3'b111, 1, 0));
        add("dn_ddr",       0, 0, 3'b111, 1,  o(6, 3'b110, 0, 0));
        add("dn_ddr_dwell", 0, 0, 3'b111, 3,  o(6, 3'b110, 0, 0));
        add("dn_core",      0, 0, 3'b111, 1,  o(7, 3'b100, 0, 0));
        add("dn_io",        0, 0, 3'b111, 4,  o(8, 3'b000, 0, 0));
        add("off_again",    0, 0, 3'b111, 4,  o(0, 3'b000, 0, 0));
        // pg_vdd_core stuck low: timeout fault, then clean exit
        add("to_en_io",     0, 1, 3'b101, 3,  o(1, 3'b100, 0, 0));
        add("to_en_core",   0, 1, 3'b101, 4,  o(2, 3'b110, 0, 0));
        add("to_wait",      0, 1, 3'b101, 31, o(2, 3'b110, 0, 0));
        add("to_fault",     0, 1, 3'b101, 1,  o(9, 3'b000, 0, 1));
        add("fault_hold",   0, 1, 3'b101, 10, o(9, 3'b000, 0, 1));
        add("fault_dwell",  0, 0, 3'b111, 5,  o(9, 3'b000, 0, 1));
        add("fault_exit",   0, 0, 3'b111, 1,  o(0, 3'b000, 0, 0));
        // ddr rail dips for 3 cycles while ON
        add("drop_on",      0, 1, 3'b111, 23, o(5, 3'b111, 1, 0));
        add("drop_sync",    0, 1, 3'b110, 2,  o(5, 3'b111, 1, 0));
        add("drop_fault",   0, 1, 3'b110, 1,  o(9, 3'b000, 0, 1));
        add("drop_latched", 0, 1, 3'b111, 5,  o(9, 3'b000, 0, 1));
        add("drop_exit",    0, 0, 3'b111, 6,  o(0, 3'b000, 0, 0));
        // Request withdrawn during EN_CORE
        add("ab_en_core",   0, 1, 3'b111, 7,  o(2, 3'b110, 0, 0));
        add("ab_sync",      0, 0, 3'b111, 2,  o(2, 3'b110, 0, 0));
        add("ab_dn_ddr",    0, 0, 3'b111, 1,  o(6, 3'b110, 0, 0));
        add("ab_dn_core",   0, 0, 3'b111, 4,  o(7, 3'b100, 0, 0));
        add("ab_dn_io",     0, 0, 3'b111, 4,  o(8, 3'b000, 0, 0));
        add("ab_off",       0, 0, 3'b111, 4,  o(0, 3'b000, 0, 0));
        split = tbl.size();
        // Reset while ON, then restart with the request still high
        add("rs_on",        0, 1, 3'b111, 23, o(5, 3'b111, 1, 0));
        add("rs_pulse",     1, 1, 3'b111, 1,  o(0, 3'b000, 0, 0));
        add("rs_sync",      0, 1, 3'b111, 2,  o(0, 3'b000, 0, 0));
        add("rs_en_io",     0, 1, 3'b111, 1,  o(1, 3'b100, 0, 0));
        add("rs_on_again",  0, 1, 3'b111, 20, o(5, 3'b111, 1, 0));

        drive(1, 0, 3'b111);
        tick(1);
        run_table(0, split);

        // Random power-good noise while OFF must not move the sequencer
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 3'($urandom_range(0, 7)));
            expect_out("pg_noise_off", o(0, 3'b000, 0, 0));
            tick(1);
            check_pop();
        end
        drive(0, 0, 3'b111);
        tick(3);

        run_table(split, tbl.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
